// File: rtl/fetch_control.sv
// Instruction fetch sequencer: issues one memory request at a time and buffers
// returned instructions with their PC in a small circular queue for dispatch.
module fetch_control #(
  parameter int          QUEUE_DEPTH_LOG = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [31:0] mem_data,
  input  logic        mem_is_compressed,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is_compressed,
  input  logic        inst_ready
);

  // state | meaning
  // IDLE  | no request outstanding, waiting for a free queue slot
  // BUSY  | request on mem_addr, waiting for mem_rdy
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;

  state_t                     state, state_next;
  logic [31:0]                pc, pc_next;
  logic                       mem_en_next;
  logic [31:0]                mem_addr_next;
  logic [31:0]                q_inst [DEPTH];
  logic [31:0]                q_pc   [DEPTH];
  logic                       q_comp [DEPTH];
  logic [QUEUE_DEPTH_LOG-1:0] head, tail;
  logic [QUEUE_DEPTH_LOG:0]   count, count_next;
  logic                       flush_go, push, pop, full_next;
  logic [31:0]                jal_imm, next_pc;

  assign flush_go   = rdy_in && flush;
  assign push       = rdy_in && !flush && (state == BUSY) && mem_rdy;
  assign pop        = rdy_in && !flush && inst_ready && inst_valid;
  assign count_next = count + (QUEUE_DEPTH_LOG+1)'(push) - (QUEUE_DEPTH_LOG+1)'(pop);
  // count never exceeds DEPTH, so the MSB alone marks a full queue
  assign full_next  = count_next[QUEUE_DEPTH_LOG];

  assign jal_imm = {{12{mem_data[31]}}, mem_data[19:12], mem_data[20], mem_data[30:21], 1'b0};
  assign next_pc = (mem_data[6:0] == 7'b1101111) ? mem_addr + jal_imm
                 : mem_addr + (mem_is_compressed ? 32'd2 : 32'd4);

  always_comb begin
    state_next    = state;
    mem_en_next   = mem_en;
    mem_addr_next = mem_addr;
    pc_next       = pc;
    if (flush_go) begin
      state_next  = IDLE;
      mem_en_next = 1'b0;
      pc_next     = flush_pc;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (!full_next) begin
            mem_en_next   = 1'b1;
            mem_addr_next = pc;
            state_next    = BUSY;
          end
        end
        BUSY: begin
          if (mem_rdy) begin
            pc_next = next_pc;
            if (!full_next) begin
              mem_addr_next = next_pc;
            end else begin
              mem_en_next = 1'b0;
              state_next  = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      mem_en   <= 1'b0;
      mem_addr <= RESET_PC;
      pc       <= RESET_PC;
    end else begin
      state    <= state_next;
      mem_en   <= mem_en_next;
      mem_addr <= mem_addr_next;
      pc       <= pc_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || flush_go) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + QUEUE_DEPTH_LOG'(1);
      if (pop)  head <= head + QUEUE_DEPTH_LOG'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      q_inst[tail] <= mem_data;
      q_pc[tail]   <= mem_addr;
      q_comp[tail] <= mem_is_compressed;
    end
  end

  assign inst_valid         = (count != '0);
  assign inst               = inst_valid ? q_inst[head] : 32'h0;
  assign inst_pc            = inst_valid ? q_pc[head]   : 32'h0;
  assign inst_is_compressed = inst_valid ? q_comp[head] : 1'b0;

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: scripted memory responses, a
// scoreboard of expected queue entries, and per-scenario checks.
module tb_fetch_control;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_rdy = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        mem_is_compressed = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_is_compressed;
  logic        inst_ready = 1'b0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
  } ent_t;

  ent_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  fetch_control #(.QUEUE_DEPTH_LOG(2), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .flush(flush), .flush_pc(flush_pc),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
    .mem_data(mem_data), .mem_is_compressed(mem_is_compressed),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_is_compressed(inst_is_compressed), .inst_ready(inst_ready)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // Wait for a request, then answer it lat cycles after it is first seen.
  task automatic mem_serve(input int lat, input logic [31:0] d, input logic comp);
    int t = 0;
    while (mem_en !== 1'b1 && t < 50) begin tick; t++; end
    if (t >= 50) begin
      n_vec++; n_err++;
      $display("FAIL mem_serve_timeout mem_en=%b required 1", mem_en);
    end
    repeat (lat - 1) tick;
    mem_rdy = 1'b1; mem_data = d; mem_is_compressed = comp;
    tick;
    mem_rdy = 1'b0; mem_is_compressed = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    flush = 1'b1; flush_pc = pc;
    tick;
    flush = 1'b0;
    tick;
    sb.delete();
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    tick; tick;
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL rst_mem_en got %b exp 0", mem_en); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid got %b exp 0", inst_valid); end
    n_vec++; if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_is_compressed !== 1'b0) begin
      n_err++; $display("FAIL rst_head got %h/%h/%b exp 0/0/0", inst, inst_pc, inst_is_compressed);
    end
    rst_in = 1'b0;
    tick;
    n_vec++; if (mem_en !== 1'b1 || mem_addr !== 32'h0) begin
      n_err++; $display("FAIL first_req got en=%b addr=%h exp en=1 addr=0", mem_en, mem_addr);
    end
  endtask

  task automatic test_fill;
    ent_t e;
    for (int k = 0; k < 4; k++) begin
      repeat (4) tick;
      n_vec++; if (mem_en !== 1'b1 || mem_addr !== 32'(k * 4)) begin
        n_err++; $display("FAIL fill_hold_%0d got en=%b addr=%h exp en=1 addr=%h", k, mem_en, mem_addr, k * 4);
      end
      mem_rdy = 1'b1; mem_data = 32'h00000013;
      sb.push_back('{inst: 32'h00000013, pc: 32'(k * 4), comp: 1'b0});
      tick;
      mem_rdy = 1'b0;
      if (k < 3) begin
        n_vec++; if (mem_en !== 1'b1 || mem_addr !== 32'((k + 1) * 4)) begin
          n_err++; $display("FAIL fill_next_%0d got en=%b addr=%h exp en=1 addr=%h", k, mem_en, mem_addr, (k + 1) * 4);
        end
      end else begin
        n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL fill_full_drop got en=%b exp 0", mem_en); end
      end
    end
    tick; tick;
    n_vec++; if (mem_en !== 1'b0 || inst_valid !== 1'b1) begin
      n_err++; $display("FAIL fill_stall got en=%b valid=%b exp en=0 valid=1", mem_en, inst_valid);
    end
    e = sb.pop_front();
    n_vec++; if (inst !== e.inst || inst_pc !== e.pc || inst_is_compressed !== e.comp) begin
      n_err++; $display("FAIL fill_head got %h/%h/%b exp %h/%h/%b", inst, inst_pc, inst_is_compressed, e.inst, e.pc, e.comp);
    end
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    n_vec++; if (mem_en !== 1'b1 || mem_addr !== 32'h10) begin
      n_err++; $display("FAIL fill_reissue got en=%b addr=%h exp en=1 addr=10", mem_en, mem_addr);
    end
    n_vec++; if (inst_pc !== sb[0].pc) begin
      n_err++; $display("FAIL fill_pop_advance got pc=%h exp %h", inst_pc, sb[0].pc);
    end
  endtask

  task automatic test_compressed;
    redirect(32'h10);
    mem_serve(1, 32'h00000513, 1'b1);
    n_vec++; if (mem_en !== 1'b1 || mem_addr !== 32'h12) begin
      n_err++; $display("FAIL comp_next got en=%b addr=%h exp en=1 addr=12", mem_en, mem_addr);
    end
    n_vec++; if (inst_valid !== 1'b1 || inst !== 32'h00000513 || inst_pc !== 32'h10 || inst_is_compressed !== 1'b1) begin
      n_err++; $display("FAIL comp_head got %b/%h/%h/%b exp 1/00000513/10/1", inst_valid, inst, inst_pc, inst_is_compressed);
    end
  endtask

  task automatic test_jal;
    redirect(32'h100);
    mem_serve(2, 32'h0080006F, 1'b0);
    n_vec++; if (mem_addr !== 32'h108) begin n_err++; $display("FAIL jal_fwd got %h exp 108", mem_addr); end
    redirect(32'h200);
    mem_serve(3, 32'hFFDFF06F, 1'b0);
    n_vec++; if (mem_addr !== 32'h1FC) begin n_err++; $display("FAIL jal_bwd got %h exp 1fc", mem_addr); end
    n_vec++; if (inst_pc !== 32'h200 || inst !== 32'hFFDFF06F) begin
      n_err++; $display("FAIL jal_head got %h/%h exp 200/ffdff06f", inst_pc, inst);
    end
  endtask

  task automatic test_flush;
    redirect(32'h300);
    mem_serve(1, 32'h00000013, 1'b0);
    mem_serve(1, 32'h00000013, 1'b0);
    mem_rdy = 1'b1; mem_data = 32'h77777713;
    flush = 1'b1; flush_pc = 32'h400;
    tick;
    mem_rdy = 1'b0; flush = 1'b0;
    n_vec++; if (inst_valid !== 1'b0 || mem_en !== 1'b0) begin
      n_err++; $display("FAIL flush_n1 got valid=%b en=%b exp 0/0", inst_valid, mem_en);
    end
    tick;
    n_vec++; if (mem_en !== 1'b1 || mem_addr !== 32'h400 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_n2 got en=%b addr=%h valid=%b exp 1/400/0", mem_en, mem_addr, inst_valid);
    end
    mem_serve(2, 32'h55500013, 1'b0);
    n_vec++; if (inst !== 32'h55500013 || inst_pc !== 32'h400) begin
      n_err++; $display("FAIL flush_discard got %h/%h exp 55500013/400", inst, inst_pc);
    end
  endtask

  task automatic test_hold;
    redirect(32'h500);
    mem_serve(1, 32'h00000013, 1'b0);
    rdy_in = 1'b0; inst_ready = 1'b1;
    mem_rdy = 1'b1; mem_data = 32'h11111113;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h500 || mem_en !== 1'b1 || mem_addr !== 32'h504) begin
        n_err++; $display("FAIL hold_%0d got valid=%b pc=%h en=%b addr=%h exp 1/500/1/504", i, inst_valid, inst_pc, mem_en, mem_addr);
      end
    end
    rdy_in = 1'b1; inst_ready = 1'b0; mem_rdy = 1'b0;
    tick;
    n_vec++; if (inst_pc !== 32'h500) begin n_err++; $display("FAIL hold_after got pc=%h exp 500", inst_pc); end
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    n_vec++; if (inst_valid !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h504) begin
      n_err++; $display("FAIL hold_count got valid=%b en=%b addr=%h exp 0/1/504", inst_valid, mem_en, mem_addr);
    end
  endtask

  task automatic test_back_to_back;
    int          issued = 0;
    int          popped = 0;
    int          budget = 0;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] d;
    ent_t        e;
    redirect(32'h0);
    inst_ready = 1'b1;
    while (popped < 10 && budget < 200) begin
      if (inst_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL stream_dup got pc=%h exp no entry", inst_pc);
        end else begin
          e = sb.pop_front();
          if (inst !== e.inst || inst_pc !== e.pc || inst_is_compressed !== e.comp) begin
            n_err++; $display("FAIL stream_pop_%0d got %h/%h exp %h/%h", popped, inst, inst_pc, e.inst, e.pc);
          end
        end
        popped++;
      end
      mem_rdy = 1'b0;
      if (mem_en === 1'b1 && issued < 10) begin
        n_vec++; if (mem_addr !== exp_addr) begin
          n_err++; $display("FAIL stream_addr_%0d got %h exp %h", issued, mem_addr, exp_addr);
        end
        d = 32'h00000013 | (32'(issued) << 20);
        mem_data = d; mem_rdy = 1'b1;
        sb.push_back('{inst: d, pc: exp_addr, comp: 1'b0});
        exp_addr = exp_addr + 32'd4;
        issued++;
      end
      tick;
      budget++;
    end
    mem_rdy = 1'b0; inst_ready = 1'b0;
    n_vec++; if (popped != 10 || sb.size() != 0) begin
      n_err++; $display("FAIL stream_total got popped=%0d left=%0d exp 10/0", popped, sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_compressed;
    test_jal;
    test_flush;
    test_hold;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_control.md
# fetch_control

Instruction fetch sequencer that drives the decoder-side request port of the memory controller. It owns the fetch PC and issues one request at a time, honouring the controller's hold-until-ready handshake. Returned instructions, already decompressed, go into a small circular queue consumed by the decoder/dispatch stage. The PC advances by 2 or 4; unconditional JAL targets are followed at fetch time. A flush redirects fetch and drops all queued and in-flight work.

## Interface
- QUEUE_DEPTH_LOG, default 2: log2 of queue depth (depth 4).
- RESET_PC, default 32'h0: fetch PC after reset.

- clk_in  in  1  clock, all state updates on rising edge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable; low means every register holds.
- flush  in  1  redirect request, acted on only when rdy_in=1.
- flush_pc  in  32  new fetch PC on flush.
- mem_en  out  1  to memory controller dec_en.
- mem_addr  out  32  to memory controller dec_addr.
- mem_rdy  in  1  dec_rdy: one-cycle pulse, data valid.
- mem_data  in  32  dec_data: 32-bit instruction.
- mem_is_compressed  in  1  dec_is_compressed: source was 16-bit.
- inst_valid  out  1  queue head valid (count != 0).
- inst  out  32  head instruction.
- inst_pc  out  32  head instruction address.
- inst_is_compressed  out  1  head compressed flag.
- inst_ready  in  1  consumer pops head this cycle when inst_valid=1 and rdy_in=1.

## Operation
- Registers: pc[31:0], FSM state, queue of 2^QUEUE_DEPTH_LOG entries {inst, pc, compressed}, head/tail pointers [QUEUE_DEPTH_LOG-1:0] that wrap naturally, count [QUEUE_DEPTH_LOG:0].
- At most one outstanding request. A slot is implicitly reserved: issue only when count < depth.
- FSM has two states:
  - IDLE: mem_en=0. If count_next < depth, set mem_en<=1, mem_addr<=pc, go to BUSY.
  - BUSY: mem_en=1; mem_addr is held constant until mem_rdy.
    - On mem_rdy: push {mem_data, mem_addr, mem_is_compressed} at tail, and pc<=next_pc.
    - Then, if count_next < depth: stay in BUSY with mem_addr<=next_pc (new address visible the cycle after rdy).
    - Otherwise: mem_en<=0 and go to IDLE.
- count_next = count + push − pop, evaluated in the same cycle.
- next_pc computation, 32-bit, wraps mod 2^32:
  - If mem_data[6:0]==7'b1101111 (JAL): next_pc = mem_addr + {{12{d[31]}}, d[19:12], d[20], d[30:21], 1'b0}.
  - Else: next_pc = mem_addr + (mem_is_compressed ? 2 : 4).
- Pop advances head. Push advances tail. Push and pop in the same cycle leave count unchanged.
- There is no bypass: an entry pushed in cycle N is visible at the head no earlier than N+1.
- inst, inst_pc, inst_is_compressed are forced to 0 whenever inst_valid=0.
- Flush (flush && rdy_in) has priority over everything:
  - count, head and tail go to 0; pc<=flush_pc; mem_en<=0; state<=IDLE.
  - A coincident mem_rdy or pop is ignored and its data discarded.
  - The memory controller resets in the same cycle, so no stale response follows.
- rst_in: same effect as flush, with pc<=RESET_PC and mem_addr<=RESET_PC. Reset is taken regardless of rdy_in.
- rdy_in=0 (and no rst_in): all state and outputs hold; inst_ready and mem_rdy are ignored.

## Timing
- Reset values:
  - mem_en=0, mem_addr=RESET_PC.
  - inst_valid=0, inst=0, inst_pc=0, inst_is_compressed=0.
  - state=IDLE, count=0.
- First request: mem_en=1 with mem_addr=RESET_PC in the first cycle after reset deasserts, given rdy_in=1.
- Latency: mem_rdy in cycle N produces inst_valid in cycle N+1 (if the queue was empty), and the next request's address is on mem_addr in cycle N+1.
- Flush in cycle N: cycle N+1 has inst_valid=0 and mem_en=0; cycle N+2 has mem_en=1 and mem_addr=flush_pc.
- Full queue: mem_en falls in the cycle after the filling mem_rdy. If a pop coincides with that mem_rdy, mem_en stays high.
- Queue wrap: pointers roll over from depth−1 to 0 with no bubble.

## Test plan
- Reset, RESET_PC=0, memory returns 32'h00000013 after 5 cycles, no pops:
  - mem_addr sequence is 0, 4, 8, 0xC.
  - mem_en drops after the 4th mem_rdy.
  - A single pop re-raises mem_en with addr 0x10 the next cycle.
- Compressed fetch: request at 0x10 answered with mem_is_compressed=1:
  - next mem_addr is 0x12.
  - head shows inst_pc=0x10, inst_is_compressed=1.
- JAL forward: at 0x100, mem_data=0x0080006F → next mem_addr 0x108.
- JAL backward: at 0x200, mem_data=0xFFDFF06F → next mem_addr 0x1FC.
- Flush coincident with mem_rdy, 2 entries queued, flush_pc=0x400:
  - responded word is not queued.
  - inst_valid=0 next cycle.
  - mem_en=0 for one cycle, then mem_en=1 with addr 0x400.
- rdy_in low for 3 cycles with inst_ready=1: head and count unchanged, mem_en/mem_addr held.
- Continuous stream, inst_ready=1 always: 10 sequential words pop in order with inst_pc 0..0x24 across pointer wrap, no loss and no duplication.
